// File: rtl/q_pkg.sv
// rtl/q_pkg.sv - shared Q-table constants, action encodings, address helper and reader FSM states
package q_pkg;

    localparam int S_WIDTH    = 6;
    localparam int A_WIDTH    = 2;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = S_WIDTH + A_WIDTH;

    localparam logic [A_WIDTH-1:0] ACT_LEFT  = 2'd0;
    localparam logic [A_WIDTH-1:0] ACT_UP    = 2'd1;
    localparam logic [A_WIDTH-1:0] ACT_RIGHT = 2'd2;
    localparam logic [A_WIDTH-1:0] ACT_DOWN  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EMIT,
        ST_FIN
    } reader_state_t;

    // Q table layout shared with the update pipeline's write path.
    function automatic logic [ADDR_WIDTH-1:0] q_addr(
        input logic [S_WIDTH-1:0] s,
        input logic [A_WIDTH-1:0] a
    );
        return {s, a};
    endfunction

endpackage

// File: rtl/q_argmax_acc.sv
// rtl/q_argmax_acc.sv - running argmax over the action entries of one state
//   clk, rst_n       : clock, asynchronous active-low reset
//   valid            : q/act carry a qualified read result this cycle
//   first            : this is the first entry of the state (load unconditionally)
//   act, q           : action index and its Q value
//   best_q, best_a   : largest Q seen so far and its action
module q_argmax_acc
    import q_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid,
    input  logic                  first,
    input  logic [A_WIDTH-1:0]    act,
    input  logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] best_q,
    output logic [A_WIDTH-1:0]    best_a
);

    // Strict unsigned compare: on ties the earlier (lower) action is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q <= '0;
            best_a <= ACT_LEFT;
        end else if (valid && (first || (q > best_q))) begin
            best_q <= q;
            best_a <= act;
        end
    end

endmodule

// File: rtl/qtable_policy_reader.sv
// rtl/qtable_policy_reader.sv - scans the Q table and streams the greedy action per state
//   clk, rst_n                       : clock, asynchronous active-low reset
//   start                            : pulse, begins a scan when idle
//   busy, done                       : scan in progress / one-cycle completion pulse
//   mem_addr, mem_rd_en, mem_rdata   : Q table read port, data one cycle after the strobe
//   out_valid, out_ready             : record handshake
//   out_state, out_action, out_q     : record contents
module qtable_policy_reader
    import q_pkg::*;
#(
    parameter int NUM_STATES = 64
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [S_WIDTH-1:0]    out_state,
    output logic [A_WIDTH-1:0]    out_action,
    output logic [DATA_WIDTH-1:0] out_q
);

    localparam logic [S_WIDTH-1:0] LAST_STATE = S_WIDTH'(NUM_STATES - 1);

    reader_state_t        state;
    logic [S_WIDTH-1:0]   state_cnt;
    logic [A_WIDTH-1:0]   a_cnt;
    logic                 rd_dly;
    logic [A_WIDTH-1:0]   a_dly;

    logic [DATA_WIDTH-1:0] best_q;
    logic [A_WIDTH-1:0]    best_a;

    // Reads are launched on the transition edge into READ so the four
    // strobes sit back to back with no setup bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            out_valid <= 1'b0;
            state_cnt <= '0;
            a_cnt     <= '0;
            rd_dly    <= 1'b0;
            a_dly     <= '0;
        end else begin
            done   <= 1'b0;
            rd_dly <= mem_rd_en;
            a_dly  <= a_cnt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_READ;
                        busy      <= 1'b1;
                        state_cnt <= '0;
                        a_cnt     <= ACT_LEFT;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= q_addr('0, ACT_LEFT);
                    end
                end
                ST_READ: begin
                    if (mem_rd_en) begin
                        if (a_cnt == ACT_DOWN) begin
                            mem_rd_en <= 1'b0;
                        end else begin
                            a_cnt    <= a_cnt + 1'b1;
                            mem_addr <= q_addr(state_cnt, a_cnt + 1'b1);
                        end
                    end
                    // Last action's data lands in the accumulator on this edge.
                    if (rd_dly && (a_dly == ACT_DOWN)) begin
                        state     <= ST_EMIT;
                        out_valid <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (state_cnt == LAST_STATE) begin
                            state <= ST_FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= ST_READ;
                            state_cnt <= state_cnt + 1'b1;
                            a_cnt     <= ACT_LEFT;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= q_addr(state_cnt + 1'b1, ACT_LEFT);
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    q_argmax_acc u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (rd_dly),
        .first  (a_dly == ACT_LEFT),
        .act    (a_dly),
        .q      (mem_rdata),
        .best_q (best_q),
        .best_a (best_a)
    );

    // Accumulator is idle during EMIT, so the record stays stable until accepted.
    assign out_state  = state_cnt;
    assign out_action = best_a;
    assign out_q      = best_q;

endmodule

// File: tb/tb_qtable_policy_reader.sv
// tb/tb_qtable_policy_reader.sv - randomized self-checking bench for qtable_policy_reader
module tb_qtable_policy_reader;
    import q_pkg::*;

    localparam int NUM = 64;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd_en;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  out_valid;
    logic                  out_ready;
    logic [S_WIDTH-1:0]    out_state;
    logic [A_WIDTH-1:0]    out_action;
    logic [DATA_WIDTH-1:0] out_q;

    qtable_policy_reader #(.NUM_STATES(NUM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_state  (out_state),
        .out_action (out_action),
        .out_q      (out_q)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic start_q = 1'b0;
    int ready_mode = 0;    // 0 always ready, 1 held low, 2 random

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        start_q <= start;
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Greedy action of a state straight from the table contents.
    task automatic ref_rec(input int s, output logic [1:0] a, output logic [31:0] q);
        q = mem[s*4];
        a = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (mem[s*4+i] > q) begin
                q = mem[s*4+i];
                a = 2'(i);
            end
        end
    endtask

    // Cycle-level expectation: phase of the scan, cycles into the current record.
    typedef enum {M_IDLE, M_RUN, M_FIN} mphase_t;
    mphase_t m_phase = M_IDLE;
    int  rec_cyc = 0;
    int  exp_state = 0;
    bit  hs_prev = 0;
    int  dones = 0;

    always @(negedge clk) begin
        logic [1:0]  ra;
        logic [31:0] rq;
        bit exp_rd;
        if (!rst_n) begin
            m_phase   = M_IDLE;
            rec_cyc   = 0;
            exp_state = 0;
            hs_prev   = 0;
        end else begin
            case (m_phase)
                M_IDLE: if (start_q) begin
                    m_phase = M_RUN; rec_cyc = 0; exp_state = 0;
                end
                M_RUN: if (hs_prev) begin
                    if (exp_state == NUM - 1) m_phase = M_FIN;
                    else begin exp_state++; rec_cyc = 0; end
                end else rec_cyc++;
                default: m_phase = M_IDLE;
            endcase
            hs_prev = 0;
            check("busy", busy, m_phase == M_RUN);
            check("done", done, m_phase == M_FIN);
            exp_rd = (m_phase == M_RUN) && (rec_cyc < 4);
            check("mem_rd_en", mem_rd_en, exp_rd);
            if (exp_rd) check("mem_addr", mem_addr, 64'(exp_state * 4 + rec_cyc));
            check("out_valid", out_valid, (m_phase == M_RUN) && (rec_cyc >= 5));
            if (out_valid) begin
                ref_rec(exp_state, ra, rq);
                check("out_state", out_state, 64'(exp_state));
                check("out_action", out_action, ra);
                check("out_q", out_q, rq);
                if (out_ready) hs_prev = 1;
            end
            if (done) dones++;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int t = 0;
        while (!done && t < limit) begin @(negedge clk); t++; end
        check("done_timeout", done, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_en"}, mem_rd_en, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_state"}, out_state, 0);
        check({tag, "_action"}, out_action, 0);
        check({tag, "_q"}, out_q, 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    endtask

    initial begin
        logic [1:0]  a;
        logic [31:0] q;
        int t, t_busy;
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'(i);
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        rst_n = 1'b1;

        // Identity table: action 3 always wins.
        ref_rec(10, a, q);
        check("pin_id_act", a, 3);
        check("pin_id_q", q, 32'h2B);
        ready_mode = 0;
        pulse_start();
        t = 0;
        while (!busy && t < 10) begin @(negedge clk); t++; end
        check("busy_rise", busy, 1);
        t_busy = cyc;
        t = 0;
        while (!out_valid && t < 30) begin @(negedge clk); t++; end
        check("first_valid_latency", 64'(cyc - t_busy), 5);
        wait_done(1000);
        check("scan_length", 64'(cyc - t_busy), 384);
        repeat (5) @(negedge clk);

        // Random table with ties, unsigned edge, backpressure, stray starts.
        fill_random();
        for (int i = 0; i < 4; i++) mem[5*4+i] = 32'h10;
        mem[6*4+0] = 32'h10; mem[6*4+1] = 32'h20; mem[6*4+2] = 32'h10; mem[6*4+3] = 32'h20;
        mem[9*4+0] = 32'h7FFFFFFF; mem[9*4+1] = 32'h0;
        mem[9*4+2] = 32'h80000000; mem[9*4+3] = 32'h0;
        ref_rec(5, a, q);
        check("pin_tie_act", a, 0);
        check("pin_tie_q", q, 32'h10);
        ref_rec(6, a, q);
        check("pin_tie2_act", a, 1);
        ref_rec(9, a, q);
        check("pin_unsigned_act", a, 2);
        check("pin_unsigned_q", q, 32'h80000000);
        ready_mode = 1;
        pulse_start();
        t = 0;
        while (!out_valid && t < 30) begin @(negedge clk); t++; end
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_rd_en", mem_rd_en, 0);
            check("bp_state", out_state, 0);
            @(negedge clk);
        end
        ready_mode = 2;
        repeat (50) @(negedge clk);
        pulse_start();
        wait_done(5000);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(negedge clk);
        check("dones_after_run2", 64'(dones), 2);

        // Reset in the middle of state 20's reads, then a fresh scan.
        fill_random();
        pulse_start();
        t = 0;
        while (!(mem_rd_en && mem_addr[7:2] == 6'd20) && t < 3000) begin @(negedge clk); t++; end
        check("reached_state20", mem_addr[7:2], 20);
        @(posedge clk); #3 rst_n = 1'b0;
        #1 check_reset_outputs("midscan_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("no_done_after_abort", 64'(dones), 2);
        pulse_start();
        wait_done(5000);
        repeat (5) @(negedge clk);
        check("total_dones", 64'(dones), 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/qtable_policy_reader.md
Name: qtable_policy_reader

Overview:
Read-side companion to the Q-learning update pipeline. After training, it scans the Q table that the pipeline writes, one state at a time. For each state it reads all four action entries and computes the greedy (argmax) action, then streams one {state, action, Q} record per state over a valid/ready interface. It sits on the Q table's read port, which the host muxes away from the update pipeline. Output feeds policy export or a debug UART.

Parameters:
S_WIDTH, 6, state index width (8x8 grid, s[5:3]=x, s[2:0]=y)
A_WIDTH, 2, action index width (4 actions)
DATA_WIDTH, 32, Q entry width, unsigned
NUM_STATES, 64, states scanned per run, 0..NUM_STATES-1

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a scan when idle
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last record handshakes
mem_addr  out  S_WIDTH+A_WIDTH  Q table read address {state, action}
mem_rd_en  out  1  read strobe
mem_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en
out_valid  out  1  record available
out_ready  in  1  downstream accepts the record
out_state  out  S_WIDTH  state of the record
out_action  out  A_WIDTH  greedy action (0 left, 1 up, 2 right, 3 down)
out_q  out  DATA_WIDTH  max Q value for the state

Behaviour:
- Reset (asynchronous, rst_n=0): FSM to IDLE. busy, done, mem_rd_en, out_valid are 0. mem_addr, out_state, out_action, out_q are 0. State and action counters are 0.
- Reset mid-scan: the scan is abandoned immediately. No record or done is produced. A new start is required after release.
- FSM states: IDLE, READ, EMIT, FIN.
- IDLE: start=1 -> READ, state_cnt=0, busy=1 next cycle. start while not IDLE is ignored.
- READ: issues 4 consecutive reads. mem_rd_en=1 and mem_addr={state_cnt, a_cnt} for a_cnt=0..3, with no gaps. A 1-cycle-delayed copy of rd_en and a_cnt qualifies mem_rdata into the argmax accumulator.
- Accumulator: on action 0 it loads (q, a). On later actions it replaces only when rdata > best, using an unsigned strict compare. Ties therefore keep the lowest action index.
- When the action-3 data is accumulated -> EMIT. out_valid rises the following cycle. Timing is 4 read cycles, then 1 cycle to the last data, then out_valid: 5 cycles from entering READ to out_valid=1.
- EMIT: out_valid=1 and out_* are held stable until out_valid&&out_ready. No reads are issued while in EMIT (mem_rd_en=0).
- On the handshake cycle, out_valid drops next cycle. If state_cnt==NUM_STATES-1 -> FIN, else state_cnt+1 and -> READ.
- FIN: done=1 for exactly one cycle and busy=0 in the same cycle, then -> IDLE. A start in the FIN cycle is ignored.
- out_ready high continuously gives a throughput of one record per 6 cycles. Full scan of 64 states = 384 cycles from start to done, plus the start-accept cycle.
- No wrap of state_cnt: it saturates at NUM_STATES-1 before FIN.
- out_ready=1 while out_valid=0 has no effect.

Decomposition:
- Shared package q_pkg:
  - S_WIDTH, A_WIDTH, DATA_WIDTH constants
  - action encodings ACT_LEFT=0, ACT_UP=1, ACT_RIGHT=2, ACT_DOWN=3
  - Q-address function {state, action}, also used by the update pipeline's write path
  - FSM state typedef
- One sub-module: q_argmax_acc. It holds the clear/load/compare-replace register pair (best_q, best_a). It has inputs valid, first, act, q and outputs best_q, best_a.

Test Plan:
- Reset then start, memory model Q[{s,a}] = {s,a} (so a=3 is max): 64 records, each out_action=3 and out_q={s,2'b11}. First out_valid 5 cycles after entering READ; done 384 cycles after busy rises.
- Ties, state 5 all entries 0x10: out_action=0, out_q=0x10. State 6 with a1=a3=0x20 and the rest 0x10: out_action=1.
- Backpressure: out_ready low for 10 cycles on state 0 record. out_valid stays high, out_* stable, mem_rd_en=0 throughout; after ready, state 1 reads begin.
- Unsigned compare, state 9 with a0=0x7FFFFFFF and a2=0x80000000: out_action=2, out_q=0x80000000.
- rst_n asserted during READ of state 20: all outputs 0 asynchronously and no done. A fresh start restarts at state 0.
- start pulsed while busy and in the FIN cycle: ignored, exactly one done per accepted start.
